// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXECUTE/MEM/WB sequencing with a
// request/ready memory handshake, wait-timeout and illegal-class trap, and a retired counter.
module multicycle_controller #(
    parameter int IMM_SEL_W = 3,
    parameter int SEL_W     = 2,
    parameter int WAIT_MAX  = 15,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 r_type,
    input  logic                 i_type,
    input  logic                 store,
    input  logic                 branch,
    input  logic                 load,
    input  logic                 jal,
    input  logic                 jalr,
    input  logic                 auipc,
    input  logic                 lui,
    input  logic                 br_taken,
    input  logic                 mem_ready,
    input  logic                 trap_clear,
    output logic                 mem_req,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 reg_write,
    output logic                 pc_write,
    output logic                 pc_sel,
    output logic [IMM_SEL_W-1:0] imme_sel,
    output logic [SEL_W-1:0]     rd_sel,
    output logic [SEL_W-1:0]     rs1_sel,
    output logic                 trap,
    output logic [CNT_W-1:0]     retired,
    output logic [2:0]           o_dbg_state
);

    // Memory handshake: mem_req is held while in FETCH/MEM; the access completes in
    // the cycle where mem_req and mem_ready are both high, and mem_req may drop after.

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_TRAP    = 3'd5
    } state_t;

    localparam int WAIT_W = $clog2(WAIT_MAX + 1);

    state_t                 r_state;
    state_t                 w_next;
    logic [WAIT_W-1:0]      r_wait;
    logic [CNT_W-1:0]       r_retired;
    logic [IMM_SEL_W-1:0]   r_imme_sel;
    logic [SEL_W-1:0]       r_rd_sel;
    logic [SEL_W-1:0]       r_rs1_sel;
    logic                   r_is_load;
    logic                   r_is_store;
    logic                   r_is_branch;
    logic                   r_is_jump;

    logic [8:0]             w_flags;
    logic                   w_legal;
    logic                   w_in_wait;
    logic                   w_expired;
    logic [IMM_SEL_W-1:0]   w_imme_sel;
    logic [SEL_W-1:0]       w_rd_sel;
    logic [SEL_W-1:0]       w_rs1_sel;
    logic                   w_mem_req;
    logic                   w_mem_write;
    logic                   w_ir_write;
    logic                   w_reg_write;
    logic                   w_pc_write;
    logic                   w_pc_sel;
    logic                   w_trap;
    logic                   w_retire;

    assign w_flags   = {r_type, i_type, store, branch, load, jal, jalr, auipc, lui};
    assign w_legal   = (w_flags != 9'd0) && ((w_flags & (w_flags - 9'd1)) == 9'd0);
    assign w_in_wait = (r_state == S_FETCH) || (r_state == S_MEM);
    // Trap once the unanswered wait would reach WAIT_MAX; a late ack in that cycle still completes.
    assign w_expired = w_in_wait && !mem_ready && (r_wait == WAIT_W'(WAIT_MAX - 1));

    always_comb begin
        w_imme_sel = '0;
        w_rd_sel   = '0;
        w_rs1_sel  = '0;
        if (i_type || load || jalr) w_imme_sel = IMM_SEL_W'(1);
        if (branch)                 w_imme_sel = IMM_SEL_W'(2);
        if (store)                  w_imme_sel = IMM_SEL_W'(3);
        if (auipc || lui)           w_imme_sel = IMM_SEL_W'(4);
        if (jal)                    w_imme_sel = IMM_SEL_W'(5);
        if (jal || jalr)            w_rd_sel   = SEL_W'(1);
        if (lui)                    w_rd_sel   = SEL_W'(2);
        if (load)                   w_rd_sel   = SEL_W'(3);
        if (auipc || branch)        w_rs1_sel  = SEL_W'(1);
        if (jal)                    w_rs1_sel  = SEL_W'(2);
        if (lui)                    w_rs1_sel  = SEL_W'(3);
    end

    always_comb begin
        w_next      = r_state;
        w_mem_req   = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_pc_write  = 1'b0;
        w_pc_sel    = 1'b0;
        w_trap      = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                if (mem_ready) begin
                    w_ir_write = 1'b1;
                    w_next     = S_DECODE;
                end else if (w_expired) begin
                    w_next = S_TRAP;
                end
            end
            S_DECODE: begin
                w_next = w_legal ? S_EXECUTE : S_TRAP;
            end
            S_EXECUTE: begin
                if (r_is_load || r_is_store) begin
                    w_next = S_MEM;
                end else if (r_is_branch) begin
                    w_pc_write = 1'b1;
                    w_pc_sel   = br_taken;
                    w_retire   = 1'b1;
                    w_next     = S_FETCH;
                end else begin
                    w_pc_sel = r_is_jump;
                    w_next   = S_WB;
                end
            end
            S_MEM: begin
                w_mem_req   = 1'b1;
                w_mem_write = r_is_store;
                if (mem_ready) begin
                    if (r_is_store) begin
                        w_pc_write = 1'b1;
                        w_retire   = 1'b1;
                        w_next     = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (w_expired) begin
                    w_next = S_TRAP;
                end
            end
            S_WB: begin
                w_reg_write = 1'b1;
                w_pc_write  = 1'b1;
                w_pc_sel    = r_is_jump;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_TRAP: begin
                w_trap = 1'b1;
                if (trap_clear) w_next = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_FETCH;
            r_wait      <= '0;
            r_retired   <= '0;
            r_imme_sel  <= '0;
            r_rd_sel    <= '0;
            r_rs1_sel   <= '0;
            r_is_load   <= 1'b0;
            r_is_store  <= 1'b0;
            r_is_branch <= 1'b0;
            r_is_jump   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_in_wait && !mem_ready && (w_next == r_state)) begin
                r_wait <= r_wait + WAIT_W'(1);
            end else begin
                r_wait <= '0;
            end
            if (w_retire) r_retired <= r_retired + CNT_W'(1);
            if ((r_state == S_DECODE) && w_legal) begin
                r_imme_sel  <= w_imme_sel;
                r_rd_sel    <= w_rd_sel;
                r_rs1_sel   <= w_rs1_sel;
                r_is_load   <= load;
                r_is_store  <= store;
                r_is_branch <= branch;
                r_is_jump   <= jal || jalr;
            end
        end
    end

    // Reset forces FETCH, whose mem_req would otherwise be high; gating keeps every strobe low while rst_n is low.
    assign mem_req     = w_mem_req   & rst_n;
    assign mem_write   = w_mem_write & rst_n;
    assign ir_write    = w_ir_write  & rst_n;
    assign reg_write   = w_reg_write & rst_n;
    assign pc_write    = w_pc_write  & rst_n;
    assign pc_sel      = w_pc_sel    & rst_n;
    assign trap        = w_trap      & rst_n;
    assign imme_sel    = r_imme_sel;
    assign rd_sel      = r_rd_sel;
    assign rs1_sel     = r_rs1_sel;
    assign retired     = r_retired;
    assign o_dbg_state = r_state;

endmodule
